mbist_sti_seq: RTL and testbench

- Parametrised MBIST stimulus sequencer; successor to the fixed 8-entry one-hot stimulus selector.
- Walks a scan-programmable enable mask over a table of STI_NUM stimulus words, skipping disabled entries in zero cycles.
- Supports multi-pass repeat and a start/next/done handshake with the MBIST FSM.
- Sits between the MBIST scan/config chain and the per-memory MBIST FSM.

---
 rtl/mbist_sti_pkg.sv | 38 +++
 rtl/mbist_sti_seq_if.sv | 30 +++
 rtl/mbist_sti_nxt_enc.sv | 26 ++
 rtl/mbist_sti_seq.sv | 167 ++++++++++++++++
 tb/tb_mbist_sti_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbist_sti_pkg.sv
// Shared types and constants for the MBIST stimulus sequencer.
// Build option MBIST_STI_USER_EN adds a scan-loadable user stimulus entry.
package mbist_sti_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } sti_state_e;

  localparam int STI_MAX = 16;

`ifdef MBIST_STI_USER_EN
  localparam int USER_ENT = 1;
`else
  localparam int USER_ENT = 0;
`endif

  // March-element encodings: [7] address direction, [6:0] op sequence code.
  localparam logic [7:0] STI_TYPE1 = 8'h01;  // legacy TYPE1: up(w0)
  localparam logic [7:0] STI_TYPE2 = 8'h8A;
  localparam logic [7:0] STI_TYPE3 = 8'h46;
  localparam logic [7:0] STI_TYPE4 = 8'hC9;
  localparam logic [7:0] STI_TYPE5 = 8'h25;
  localparam logic [7:0] STI_TYPE6 = 8'hA6;
  localparam logic [7:0] STI_TYPE7 = 8'h5C;
  localparam logic [7:0] STI_TYPE8 = 8'hF3;

  localparam logic [63:0] STI_TABLE_DFLT = {
    STI_TYPE8, STI_TYPE7, STI_TYPE6, STI_TYPE5,
    STI_TYPE4, STI_TYPE3, STI_TYPE2, STI_TYPE1
  };

  function automatic int idx_wd(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbist_sti_seq_if.sv
// Handshake and stimulus bus between the MBIST FSM (master) and the sequencer (slave).
interface mbist_sti_seq_if
  import mbist_sti_pkg::*;
#(
  parameter int STI_WD     = 8,
  parameter int STI_IDX_WD = idx_wd(8 + USER_ENT),
  parameter int RPT_WD     = 4
);

  logic                  start;
  logic                  next;
  logic [RPT_WD-1:0]     rpt;
  logic [STI_WD-1:0]     stimulus;
  logic [STI_IDX_WD-1:0] sti_idx;
  logic                  sti_valid;
  logic                  last_stimulus;
  logic                  busy;
  logic                  done;

  modport master (
    output start, next, rpt,
    input  stimulus, sti_idx, sti_valid, last_stimulus, busy, done
  );

  modport slave (
    input  start, next, rpt,
    output stimulus, sti_idx, sti_valid, last_stimulus, busy, done
  );

endinterface

// File: rtl/mbist_sti_nxt_enc.sv
// Finds the lowest set mask bit at/above (incl_base=1) or strictly above (incl_base=0) base.
module mbist_sti_nxt_enc #(
  parameter int N      = 8,
  parameter int IDX_WD = 3
) (
  input  logic [N-1:0]      mask,
  input  logic [IDX_WD-1:0] base,
  input  logic              incl_base,
  output logic              found,
  output logic [IDX_WD-1:0] idx
);

  // Priority scan from bit 0 upward; first qualifying bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && mask[i] &&
          ((IDX_WD'(i) > base) || (incl_base && (IDX_WD'(i) == base)))) begin
        found = 1'b1;
        idx   = IDX_WD'(i);
      end
    end
  end

endmodule

// File: rtl/mbist_sti_seq.sv
// MBIST stimulus sequencer: walks a scan-programmed enable mask over the stimulus
// table with multi-pass repeat. Define MBIST_STI_USER_EN for an extra scan-loaded
// user entry at index STI_NUM.
module mbist_sti_seq
  import mbist_sti_pkg::*;
#(
  parameter int                        STI_NUM    = 8,
  parameter int                        STI_WD     = 8,
  parameter int                        STI_IDX_WD = idx_wd(STI_NUM + USER_ENT),
  parameter int                        RPT_WD     = 4,
  parameter logic [STI_NUM*STI_WD-1:0] STI_TABLE  = STI_TABLE_DFLT,
  parameter logic [STI_NUM-1:0]        MASK_RST   = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_shift,
  input  logic                  sdi,
  output logic                  sdo,
  mbist_sti_seq_if.slave        bus
);

  localparam int N_ENT = STI_NUM + USER_ENT;
  localparam logic [N_ENT-1:0] MASK_RST_FULL = N_ENT'(MASK_RST);

  sti_state_e            state_q, state_d;
  logic [N_ENT-1:0]      mask_q, mask_d;
  logic [STI_IDX_WD-1:0] sti_idx_q, sti_idx_d;
  logic [RPT_WD-1:0]     pass_cnt_q, pass_cnt_d;
  logic [RPT_WD-1:0]     rpt_q, rpt_d;
  logic [STI_WD-1:0]     stimulus_q, stimulus_d;
`ifdef MBIST_STI_USER_EN
  logic [STI_WD-1:0]     user_sti_q, user_sti_d;
`endif

  logic                  first_found;
  logic [STI_IDX_WD-1:0] first_idx;
  logic                  has_nxt;
  logic [STI_IDX_WD-1:0] nxt_idx;

  mbist_sti_nxt_enc #(
    .N      (N_ENT),
    .IDX_WD (STI_IDX_WD)
  ) u_first_enc (
    .mask      (mask_q),
    .base      ('0),
    .incl_base (1'b1),
    .found     (first_found),
    .idx       (first_idx)
  );

  mbist_sti_nxt_enc #(
    .N      (N_ENT),
    .IDX_WD (STI_IDX_WD)
  ) u_nxt_enc (
    .mask      (mask_q),
    .base      (sti_idx_q),
    .incl_base (1'b0),
    .found     (has_nxt),
    .idx       (nxt_idx)
  );

  // Config chain shift: sdi -> [user_sti] -> mask -> sdo, LSB exits first.
  always_comb begin
    mask_d = mask_q;
`ifdef MBIST_STI_USER_EN
    user_sti_d = user_sti_q;
    if (scan_shift) begin
      user_sti_d = STI_WD'({sdi, user_sti_q} >> 1);
      mask_d     = N_ENT'({user_sti_q[0], mask_q} >> 1);
    end
`else
    if (scan_shift) begin
      mask_d = N_ENT'({sdi, mask_q} >> 1);
    end
`endif
  end

  assign sdo = mask_q[0];

  // Sequencer next-state: scan_shift aborts from any state and blocks start.
  always_comb begin
    state_d    = state_q;
    sti_idx_d  = sti_idx_q;
    pass_cnt_d = pass_cnt_q;
    rpt_d      = rpt_q;
    if (scan_shift) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (first_found) begin
              state_d    = ACTIVE;
              sti_idx_d  = first_idx;
              pass_cnt_d = '0;
              rpt_d      = bus.rpt;
            end else begin
              state_d = DONE;
            end
          end
        end
        ACTIVE: begin
          if (bus.next) begin
            if (has_nxt) begin
              sti_idx_d = nxt_idx;
            end else if (pass_cnt_q < rpt_q) begin
              sti_idx_d  = first_idx;
              pass_cnt_d = pass_cnt_q + RPT_WD'(1);
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Stimulus is looked up from the next index so it tracks sti_idx without lag.
  always_comb begin
    stimulus_d = STI_TABLE[STI_WD-1:0];
    for (int unsigned i = 0; i < STI_NUM; i++) begin
      if (sti_idx_d == STI_IDX_WD'(i)) begin
        stimulus_d = STI_TABLE[i*STI_WD +: STI_WD];
      end
    end
`ifdef MBIST_STI_USER_EN
    if (sti_idx_d == STI_IDX_WD'(STI_NUM)) begin
      stimulus_d = user_sti_d;
    end
`endif
  end

  // State, config and stimulus registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= MASK_RST_FULL;
      sti_idx_q  <= '0;
      pass_cnt_q <= '0;
      rpt_q      <= '0;
      stimulus_q <= STI_TABLE[STI_WD-1:0];
`ifdef MBIST_STI_USER_EN
      user_sti_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      sti_idx_q  <= sti_idx_d;
      pass_cnt_q <= pass_cnt_d;
      rpt_q      <= rpt_d;
      stimulus_q <= stimulus_d;
`ifdef MBIST_STI_USER_EN
      user_sti_q <= user_sti_d;
`endif
    end
  end

  assign bus.stimulus      = stimulus_q;
  assign bus.sti_idx       = sti_idx_q;
  assign bus.sti_valid     = (state_q == ACTIVE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.last_stimulus = bus.sti_valid & ~has_nxt & (pass_cnt_q == rpt_q);

endmodule

// File: tb/tb_mbist_sti_seq.sv
// Self-checking bench for mbist_sti_seq; covers MBIST_STI_USER_EN when defined.
module tb_mbist_sti_seq;

  localparam int NUM = 8;
  localparam int WD  = 8;
  localparam int RW  = 4;
`ifdef MBIST_STI_USER_EN
  localparam int NE = NUM + 1;
  localparam int CH = WD + NUM + 1;
`else
  localparam int NE = NUM;
  localparam int CH = NUM;
`endif
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int OW = 4 + IW + WD;

  logic clk = 1'b0;
  logic rst_n;
  logic scan_shift;
  logic sdi;
  logic sdo;

  mbist_sti_seq_if #(.STI_WD(WD), .STI_IDX_WD(IW), .RPT_WD(RW)) bus ();

  mbist_sti_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_shift (scan_shift),
    .sdi        (sdi),
    .sdo        (sdo),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: the whole config chain as {user_sti, mask} (or just mask).
  logic [CH-1:0]     chain_m;
  logic [NUM*WD-1:0] tbl;

  function automatic logic [CH-1:0] mk_chain(input logic [WD-1:0] u, input logic [NE-1:0] m);
`ifdef MBIST_STI_USER_EN
    return {u, m};
`else
    if (u != u) return '0;
    return m;
`endif
  endfunction

  function automatic logic [WD-1:0] ref_stim(input int idx);
    if (idx < NUM) return tbl[idx*WD +: WD];
    return chain_m[CH-1 -: WD];
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.sti_valid, bus.busy, bus.done, bus.last_stimulus, bus.sti_idx, bus.stimulus};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.sti_valid, bus.busy, bus.done, bus.last_stimulus};
  endfunction

  // Shift a full chain length; sdo must present the previous chain contents.
  task automatic load_chain(input logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (sdo !== chain_m[0]) begin
        failures++;
        $display("FAIL scan_sdo bit=%0d got=%b exp=%b", i, sdo, chain_m[0]);
      end
      scan_shift = 1'b1;
      sdi        = v[i];
      @(negedge clk);
      chain_m = {v[i], chain_m[CH-1:1]};
    end
    scan_shift = 1'b0;
    sdi        = 1'b0;
  endtask

  // Start a sequence with the model mask and walk it to completion.
  task automatic run_seq(input logic [RW-1:0] r, input bit poke_start, input bit gaps);
    int q[$];
    logic [NE-1:0] m;
    logic [OW-1:0] exp_o;
    m = chain_m[NE-1:0];
    for (int p = 0; p <= int'(r); p++)
      for (int i = 0; i < NE; i++)
        if (m[i]) q.push_back(i);
    bus.start = 1'b1;
    bus.rpt   = r;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rpt   = RW'($urandom);
    for (int k = 0; k < q.size(); k++) begin
      exp_o = {1'b1, 1'b1, 1'b0, (k == q.size() - 1), IW'(q[k]), ref_stim(q[k])};
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          checks++;
          if (obs() !== exp_o) begin
            failures++;
            $display("FAIL seq_hold step=%0d got=%h exp=%h", k, obs(), exp_o);
          end
          @(negedge clk);
        end
      end
      checks++;
      if (obs() !== exp_o) begin
        failures++;
        $display("FAIL seq_step step=%0d got=%h exp=%h", k, obs(), exp_o);
      end
      bus.next  = 1'b1;
      bus.start = poke_start && (k == q.size() / 2);
      @(negedge clk);
      bus.next  = 1'b0;
      bus.start = 1'b0;
    end
    checks++;
    if (flags() !== 4'b0110) begin
      failures++;
      $display("FAIL seq_done got=%b exp=%b", flags(), 4'b0110);
    end
    @(negedge clk);
    checks++;
    if (flags() !== 4'b0000) begin
      failures++;
      $display("FAIL seq_idle got=%b exp=%b", flags(), 4'b0000);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== {4'b0000, IW'(0), tbl[WD-1:0]} || sdo !== chain_m[0]) begin
      failures++;
      $display("FAIL reset_state got=%h/%b exp=%h/%b", obs(), sdo,
               {4'b0000, IW'(0), tbl[WD-1:0]}, chain_m[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== {4'b0000, IW'(0), tbl[WD-1:0]}) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs(), {4'b0000, IW'(0), tbl[WD-1:0]});
    end
  endtask

  task automatic test_basic();
    run_seq('0, 1'b0, 1'b0);
  endtask

  task automatic test_pattern();
    load_chain(mk_chain('0, NE'(8'b1010_0100)));
    run_seq(RW'(1), 1'b0, 1'b0);
  endtask

  task automatic test_empty_mask();
    load_chain(mk_chain('0, '0));
    run_seq(RW'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_idle_next();
    bus.next = 1'b1;
    @(negedge clk);
    bus.next = 1'b0;
    checks++;
    if (flags() !== 4'b0000) begin
      failures++;
      $display("FAIL idle_next got=%b exp=%b", flags(), 4'b0000);
    end
  endtask

  task automatic test_abort();
    logic b;
    load_chain(mk_chain('0, NE'(8'hFF)));
    bus.start = 1'b1;
    bus.rpt   = '0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      bus.next = 1'b1;
      @(negedge clk);
      bus.next = 1'b0;
    end
    checks++;
    if (obs() !== {4'b1100, IW'(3), ref_stim(3)}) begin
      failures++;
      $display("FAIL abort_pre got=%h exp=%h", obs(), {4'b1100, IW'(3), ref_stim(3)});
    end
    b          = 1'($urandom);
    scan_shift = 1'b1;
    sdi        = b;
    @(negedge clk);
    scan_shift = 1'b0;
    chain_m    = {b, chain_m[CH-1:1]};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (flags() !== 4'b0000) begin
        failures++;
        $display("FAIL abort_idle cyc=%0d got=%b exp=%b", i, flags(), 4'b0000);
      end
      @(negedge clk);
    end
    run_seq('0, 1'b0, 1'b0);
  endtask

  task automatic test_start_scan();
    bus.start  = 1'b1;
    scan_shift = 1'b1;
    sdi        = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    scan_shift = 1'b0;
    chain_m    = {1'b1, chain_m[CH-1:1]};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (flags() !== 4'b0000) begin
        failures++;
        $display("FAIL start_scan cyc=%0d got=%b exp=%b", i, flags(), 4'b0000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rpt_max();
    load_chain(mk_chain('0, NE'(8'h01)));
    run_seq('1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    repeat (6) begin
      load_chain(CH'({$urandom, $urandom}));
      run_seq(RW'($urandom_range(0, 3)), 1'b1, 1'b1);
    end
  endtask

`ifdef MBIST_STI_USER_EN
  task automatic test_user_entry();
    load_chain(mk_chain(8'hA5, NE'(1) << NUM));
    run_seq('0, 1'b0, 1'b0);
    load_chain(CH'({$urandom, $urandom}));
    run_seq(RW'(1), 1'b0, 1'b1);
  endtask
`endif

  initial begin
    tbl        = mbist_sti_pkg::STI_TABLE_DFLT;
    chain_m    = mk_chain('0, NE'(8'hFF));
    rst_n      = 1'b0;
    scan_shift = 1'b0;
    sdi        = 1'b0;
    bus.start  = 1'b0;
    bus.next   = 1'b0;
    bus.rpt    = '0;
    test_reset();
    test_basic();
    test_pattern();
    test_empty_mask();
    test_idle_next();
    test_abort();
    test_start_scan();
    test_rpt_max();
    test_random();
`ifdef MBIST_STI_USER_EN
    test_user_entry();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
